// File: rtl/duty_scheduler.sv
// Duty-word scheduler for a digital PWM converter.
// Accepts compensator duty requests through a one-entry pending register,
// soft-starts the duty word from its current value up to the requested
// target, follows new requests in RUN and ramps down to zero on shutdown.
// All duty, target and state changes tied to the PWM period happen on the
// last count (63) so that a new duty word is valid from count 0.
module duty_scheduler #(
  parameter int SS_STEP = 4,
  parameter int D_MAX   = 52,
  parameter int D_MIN   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [5:0] pwm_count,
  input  logic [5:0] duty_req,
  input  logic       req_valid,
  output logic       req_ready,
  output logic [5:0] d_n,
  output logic       pwm_en,
  output logic       ss_done,
  output logic       clamp_pulse,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SOFTSTART = 2'd1,
    ST_RUN       = 2'd2,
    ST_SHUTDOWN  = 2'd3
  } state_t;

  localparam logic [5:0] D_MAX_C   = 6'(D_MAX);
  localparam logic [5:0] D_MIN_C   = 6'(D_MIN);
  localparam logic [3:0] SS_LAST_C = 4'(SS_STEP - 1);

  // Limit a requested duty into [D_MIN, D_MAX].
  function automatic logic [5:0] clamp_duty(input logic [5:0] v);
    logic [5:0] r;
    if (v < D_MIN_C) begin
      r = D_MIN_C;
    end else if (v > D_MAX_C) begin
      r = D_MAX_C;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // True when a request falls outside the clamp window.
  function automatic logic out_of_range(input logic [5:0] v);
    return (v < D_MIN_C) || (v > D_MAX_C);
  endfunction

  state_t     state_r, state_s;
  logic [5:0] d_n_r, d_n_s;
  logic       pend_full_r, pend_full_s;
  logic [5:0] pend_val_r, pend_val_s;
  logic [5:0] target_r, target_s;
  logic [3:0] ss_cnt_r, ss_cnt_s;
  logic       req_ready_r, req_ready_s;
  logic       pwm_en_r, pwm_en_s;
  logic       ss_done_r, ss_done_s;
  logic       clamp_pulse_r, clamp_pulse_s;

  logic       period_end_s;
  logic       accept_s;
  logic [5:0] tgt_s;
  logic [6:0] d_inc_s;

  // Next-state, duty and pending-register logic.
  always_comb begin
    state_s      = state_r;
    d_n_s        = d_n_r;
    pend_full_s  = pend_full_r;
    pend_val_s   = pend_val_r;
    target_s     = target_r;
    ss_cnt_s     = ss_cnt_r;
    period_end_s = (pwm_count == 6'd63);
    accept_s     = req_valid && req_ready_r;
    tgt_s        = pend_full_r ? pend_val_r : target_r;
    d_inc_s      = {1'b0, d_n_r} + 7'd1;

    // A request is only accepted while pending is empty, so it never
    // collides with the period_end consumption of pending below.
    if (accept_s) begin
      pend_full_s = 1'b1;
      pend_val_s  = clamp_duty(duty_req);
    end else begin
      pend_full_s = pend_full_r;
    end

    case (state_r)
      ST_IDLE: begin
        d_n_s = 6'd0;
        if (enable) begin
          state_s  = ST_SOFTSTART;
          ss_cnt_s = 4'd0;
          target_s = D_MIN_C;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SOFTSTART: begin
        if (!enable) begin
          state_s     = ST_SHUTDOWN;
          pend_full_s = 1'b0;
        end else if (period_end_s) begin
          if (pend_full_r) begin
            target_s    = pend_val_r;
            pend_full_s = 1'b0;
          end else begin
            target_s = target_r;
          end
          // Finish the ramp one step early, or at once if the target
          // now lies below the current duty.
          if ((d_inc_s >= {1'b0, tgt_s}) || (tgt_s < d_n_r)) begin
            d_n_s   = tgt_s;
            state_s = ST_RUN;
          end else if (ss_cnt_r >= SS_LAST_C) begin
            d_n_s    = d_n_r + 6'd1;
            ss_cnt_s = 4'd0;
          end else begin
            ss_cnt_s = ss_cnt_r + 4'd1;
          end
        end else begin
          state_s = ST_SOFTSTART;
        end
      end

      ST_RUN: begin
        if (!enable) begin
          state_s     = ST_SHUTDOWN;
          pend_full_s = 1'b0;
        end else if (period_end_s && pend_full_r) begin
          d_n_s       = pend_val_r;
          pend_full_s = 1'b0;
        end else begin
          state_s = ST_RUN;
        end
      end

      ST_SHUTDOWN: begin
        pend_full_s = 1'b0;
        if (period_end_s) begin
          if (enable) begin
            state_s  = ST_SOFTSTART;
            ss_cnt_s = 4'd0;
            target_s = D_MIN_C;
          end else if (d_n_r == 6'd0) begin
            state_s = ST_IDLE;
          end else begin
            d_n_s = d_n_r - 6'd1;
          end
        end else begin
          state_s = ST_SHUTDOWN;
        end
      end

      default: begin
        state_s     = ST_IDLE;
        d_n_s       = 6'd0;
        pend_full_s = 1'b0;
      end
    endcase

    req_ready_s   = ((state_s == ST_SOFTSTART) || (state_s == ST_RUN)) && !pend_full_s;
    pwm_en_s      = (state_s != ST_IDLE);
    ss_done_s     = (state_s == ST_RUN);
    clamp_pulse_s = accept_s && out_of_range(duty_req);
  end

  // State, duty and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      d_n_r         <= 6'd0;
      pend_full_r   <= 1'b0;
      pend_val_r    <= 6'd0;
      target_r      <= D_MIN_C;
      ss_cnt_r      <= 4'd0;
      req_ready_r   <= 1'b0;
      pwm_en_r      <= 1'b0;
      ss_done_r     <= 1'b0;
      clamp_pulse_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      d_n_r         <= d_n_s;
      pend_full_r   <= pend_full_s;
      pend_val_r    <= pend_val_s;
      target_r      <= target_s;
      ss_cnt_r      <= ss_cnt_s;
      req_ready_r   <= req_ready_s;
      pwm_en_r      <= pwm_en_s;
      ss_done_r     <= ss_done_s;
      clamp_pulse_r <= clamp_pulse_s;
    end
  end

  assign state       = state_r;
  assign d_n         = d_n_r;
  assign req_ready   = req_ready_r;
  assign pwm_en      = pwm_en_r;
  assign ss_done     = ss_done_r;
  assign clamp_pulse = clamp_pulse_r;

endmodule
